// File: rtl/orient_scan_ctrl.sv
// Scan-order sequencer: walks a DIM x DIM frame once in 0/90/45/135 degree line
// order and emits one (row, col) coordinate per valid/ready beat with line markers.
module orient_scan_ctrl #(
  parameter int DIM = 1024,
  parameter int W   = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   orient,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         addr_valid,
  input  logic         addr_ready,
  output logic [W-1:0] row,
  output logic [W-1:0] col,
  output logic         line_start,
  output logic         line_end,
  output logic [W:0]   line_idx,
  output logic [1:0]   fsm_state
);

  // Handshake: a beat completes on a rising edge where addr_valid && addr_ready;
  // while addr_valid is high and addr_ready low, all coordinate outputs hold.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [W:0]   N_M1      = (W+1)'(DIM - 1);
  localparam logic [W-1:0] MAX_C     = W'(DIM - 1);
  localparam logic [W:0]   LAST_DIAG = (W+1)'(2 * DIM - 2);

  state_t       state, state_n;
  logic [1:0]   orient_q, orient_n;
  logic [W-1:0] row_n, col_n;
  logic         ls_q, ls_n, le_q, le_n;
  logic [W:0]   idx_n;
  logic [W:0]   last_idx;
  logic         beat;

  // First pixel of line d; compares precede every subtraction so nothing wraps.
  function automatic logic [2*W-1:0] line_first(input logic [1:0] o, input logic [W:0] d);
    logic [W-1:0] r, c;
    r = '0;
    c = '0;
    case (o)
      2'd0: r = d[W-1:0];
      2'd1: c = d[W-1:0];
      2'd2: begin
        if (d >= N_M1) begin
          r = W'(d - N_M1);
          c = MAX_C;
        end else begin
          c = d[W-1:0];
        end
      end
      default: begin
        if (d <= N_M1) r = W'(N_M1 - d);
        else           c = W'(d - N_M1);
      end
    endcase
    return {r, c};
  endfunction

  function automatic logic is_end(input logic [1:0] o, input logic [W-1:0] r, input logic [W-1:0] c);
    logic e;
    case (o)
      2'd0:    e = (c == MAX_C);
      2'd1:    e = (r == MAX_C);
      2'd2:    e = (r == MAX_C) || (c == '0);
      default: e = (r == MAX_C) || (c == MAX_C);
    endcase
    return e;
  endfunction

  assign last_idx = orient_q[1] ? LAST_DIAG : N_M1;
  assign beat     = (state == RUN) && addr_ready;

  always_comb begin
    state_n  = state;
    orient_n = orient_q;
    row_n    = row;
    col_n    = col;
    ls_n     = ls_q;
    le_n     = le_q;
    idx_n    = line_idx;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n        = RUN;
          orient_n       = orient;
          idx_n          = '0;
          {row_n, col_n} = line_first(orient, '0);
          ls_n           = 1'b1;
          le_n           = is_end(orient, row_n, col_n);
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (beat) begin
          if (le_q && (line_idx == last_idx)) begin
            state_n = FIN;
          end else if (le_q) begin
            idx_n          = line_idx + (W+1)'(1);
            {row_n, col_n} = line_first(orient_q, idx_n);
            ls_n           = 1'b1;
            le_n           = is_end(orient_q, row_n, col_n);
          end else begin
            case (orient_q)
              2'd0: col_n = col + W'(1);
              2'd1: row_n = row + W'(1);
              2'd2: begin
                row_n = row + W'(1);
                col_n = col - W'(1);
              end
              default: begin
                row_n = row + W'(1);
                col_n = col + W'(1);
              end
            endcase
            ls_n = 1'b0;
            le_n = is_end(orient_q, row_n, col_n);
          end
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      orient_q <= '0;
      row      <= '0;
      col      <= '0;
      ls_q     <= 1'b0;
      le_q     <= 1'b0;
      line_idx <= '0;
    end else begin
      state    <= state_n;
      orient_q <= orient_n;
      row      <= row_n;
      col      <= col_n;
      ls_q     <= ls_n;
      le_q     <= le_n;
      line_idx <= idx_n;
    end
  end

  assign addr_valid = (state == RUN);
  assign busy       = (state == RUN);
  assign done       = (state == FIN);
  assign line_start = ls_q & addr_valid;
  assign line_end   = le_q & addr_valid;
  assign fsm_state  = state;

endmodule

// File: tb/tb_orient_scan_ctrl.sv
// Bench for orient_scan_ctrl at DIM=4: expected beat order is built from the
// geometric definition of each orientation and compared beat by beat.
module tb_orient_scan_ctrl;

  localparam int DIM = 4;
  localparam int W   = 2;
  localparam int BW  = 2 + (W + 1) + 2 * W;

  logic         clk = 1'b0;
  logic         reset, start, abort, addr_ready;
  logic [1:0]   orient;
  logic         busy, done, addr_valid, line_start, line_end;
  logic [W-1:0] row, col;
  logic [W:0]   line_idx;
  logic [1:0]   fsm_state;
  logic [BW-1:0] obs;

  int checks   = 0;
  int failures = 0;
  logic [BW-1:0] exp_q[$];

  orient_scan_ctrl #(.DIM(DIM), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .orient(orient), .abort(abort),
    .busy(busy), .done(done), .addr_valid(addr_valid), .addr_ready(addr_ready),
    .row(row), .col(col), .line_start(line_start), .line_end(line_end),
    .line_idx(line_idx), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  assign obs = {line_start, line_end, line_idx, row, col};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pixels on line l, listed in increasing row (or col for 0 deg) order.
  task automatic build_exp(input int o);
    int nlines;
    exp_q.delete();
    nlines = (o < 2) ? DIM : 2 * DIM - 1;
    for (int l = 0; l < nlines; l++) begin
      int lr[$];
      int lc[$];
      for (int k = 0; k < DIM; k++) begin
        int c;
        case (o)
          0: begin lr.push_back(l); lc.push_back(k); end
          1: begin lr.push_back(k); lc.push_back(l); end
          2: begin
            c = l - k;
            if (c >= 0 && c < DIM) begin lr.push_back(k); lc.push_back(c); end
          end
          default: begin
            c = k + l - (DIM - 1);
            if (c >= 0 && c < DIM) begin lr.push_back(k); lc.push_back(c); end
          end
        endcase
      end
      for (int k = 0; k < lr.size(); k++)
        exp_q.push_back({(k == 0), (k == lr.size() - 1), (W+1)'(l), W'(lr[k]), W'(lc[k])});
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_valid"}, addr_valid, 0);
    check_eq({tag, "_row"}, row, 0);
    check_eq({tag, "_col"}, col, 0);
    check_eq({tag, "_ls"}, line_start, 0);
    check_eq({tag, "_le"}, line_end, 0);
    check_eq({tag, "_idx"}, line_idx, 0);
  endtask

  // mode 0: ready high; 1: ready toggles 1-0-1-0; 2: random ready plus stray starts.
  task automatic run_scan(input int o, input int mode, input int abort_at, input int reset_at);
    int beats;
    bit tgl;
    beats = 0;
    tgl   = 1'b1;
    build_exp(o);
    @(negedge clk);
    start  = 1'b1;
    orient = 2'(o);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("valid_after_start", addr_valid, 1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      case (mode)
        0: addr_ready = 1'b1;
        1: begin addr_ready = tgl; tgl = !tgl; end
        default: addr_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        start  = 1'b1;
        orient = 2'($urandom_range(0, 3));
      end else begin
        start = 1'b0;
      end
      if (addr_valid !== 1'b1 || exp_q.size() == 0) begin
        check_eq("valid_in_run", addr_valid, 1);
        check_eq("beats_remaining", (exp_q.size() != 0), 1);
        start = 1'b0;
        return;
      end
      check_eq("beat", obs, exp_q[0]);
      check_eq("busy_in_run", busy, 1);
      check_eq("done_in_run", done, 0);
      if (addr_ready) begin
        if (beats == abort_at) begin
          abort = 1'b1;
          @(negedge clk);
          abort = 1'b0; start = 1'b0; addr_ready = 1'b0;
          check_eq("abort_valid", addr_valid, 0);
          check_eq("abort_busy", busy, 0);
          check_eq("abort_done", done, 0);
          repeat (2) begin
            @(negedge clk);
            check_eq("abort_no_done", done, 0);
          end
          return;
        end
        if (beats == reset_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0; start = 1'b0; addr_ready = 1'b0;
          check_reset_values("mid_reset");
          return;
        end
        void'(exp_q.pop_front());
        beats++;
        if (exp_q.size() == 0) begin
          @(negedge clk);
          addr_ready = 1'b0;
          start      = 1'b1;
          orient     = 2'd0;
          check_eq("done_pulse", done, 1);
          check_eq("busy_at_done", busy, 0);
          check_eq("valid_at_done", addr_valid, 0);
          check_eq("beat_count", beats, DIM * DIM);
          @(negedge clk);
          start = 1'b0;
          check_eq("done_single", done, 0);
          check_eq("start_in_fin_ignored", busy, 0);
          check_eq("idle_valid", addr_valid, 0);
          return;
        end
      end
      @(negedge clk);
    end
    check_eq("scan_timeout", 0, 1);
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b0; orient = 2'd0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    run_scan(0, 0, -1, -1);
    run_scan(2, 0, -1, -1);
    run_scan(3, 1, -1, -1);
    run_scan(1, 2, -1, -1);
    run_scan(0, 0, 5, -1);
    run_scan(0, 0, -1, -1);

    @(negedge clk);
    start = 1'b1; abort = 1'b1; orient = 2'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("idle_abort_wins_busy", busy, 0);
    check_eq("idle_abort_wins_valid", addr_valid, 0);

    run_scan(2, 2, -1, 7);
    run_scan(3, 2, -1, -1);
    for (int i = 0; i < 6; i++)
      run_scan(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
